// File: rtl/vga_sync_module_pkg.sv
// Shared VGA timing set (640x480@60 defaults), derived totals and FSM encoding
// used by the sync generator and its axis counters.
package vga_sync_module_pkg;

  localparam int unsigned H_ACT    = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACT    = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned P_WIDTH  = 11;
  localparam int unsigned D_WIDTH  = 8;
  localparam bit          SYNC_POL = 1'b0;

  function automatic int unsigned axis_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOT = axis_total(H_ACT, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOT = axis_total(V_ACT, V_FP, V_SYNC, V_BP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } vga_state_e;

endpackage

// File: rtl/vga_sync_module_axis.sv
// One raster axis: wrapping position counter plus active-area and sync-window decode.
module vga_axis_counter
  import vga_sync_module_pkg::*;
#(
  parameter int unsigned ACT  = H_ACT,
  parameter int unsigned FP   = H_FP,
  parameter int unsigned SYNC = H_SYNC,
  parameter int unsigned BP   = H_BP,
  parameter int unsigned W    = P_WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         step_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o,
  output logic         active_o,
  output logic         sync_o
);

  localparam int unsigned  TOT      = axis_total(ACT, FP, SYNC, BP);
  localparam logic [W-1:0] LAST     = W'(TOT - 1);
  localparam logic [W-1:0] ACT_END  = W'(ACT);
  localparam logic [W-1:0] SYNC_BEG = W'(ACT + FP);
  localparam logic [W-1:0] SYNC_END = W'(ACT + FP + SYNC);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (step_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign last_o   = (cnt_q == LAST);
  assign active_o = (cnt_q < ACT_END);
  assign sync_o   = (cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END);

endmodule

// File: rtl/vga_sync_module.sv
// VGA raster timing generator: IDLE/RUN/STOP control, H/V axis counters and
// registered pixel, sync, start-of-frame and frame-count outputs.
module vga_sync_module
  import vga_sync_module_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACT,
  parameter int unsigned H_FPORCH   = H_FP,
  parameter int unsigned H_SWIDTH   = H_SYNC,
  parameter int unsigned H_BPORCH   = H_BP,
  parameter int unsigned V_ACTIVE   = V_ACT,
  parameter int unsigned V_FPORCH   = V_FP,
  parameter int unsigned V_SWIDTH   = V_SYNC,
  parameter int unsigned V_BPORCH   = V_BP,
  parameter int unsigned COORD_W    = P_WIDTH,
  parameter bit          SYNC_LEVEL = SYNC_POL
) (
  input  logic               VGA_CLK,
  input  logic               RST_N,
  input  logic               EN,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  output logic               valid,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               SOF,
  output logic               BUSY,
  output logic [D_WIDTH-1:0] FRAME_CNT
);

  vga_state_e state_q, state_d;

  logic               run;
  logic               frameEnd;
  logic [COORD_W-1:0] hCnt, vCnt;
  logic               hLast, vLast;
  logic               hActive, vActive;
  logic               hSyncWin, vSyncWin;

  logic [COORD_W-1:0] xPos_q, xPos_d;
  logic [COORD_W-1:0] yPos_q, yPos_d;
  logic               valid_q, valid_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               sof_q, sof_d;
  logic               busy_q, busy_d;
  logic [D_WIDTH-1:0] frameCnt_q, frameCnt_d;

  assign run      = (state_q != ST_IDLE);
  assign frameEnd = run && hLast && vLast;

  vga_axis_counter #(
    .ACT  (H_ACTIVE),
    .FP   (H_FPORCH),
    .SYNC (H_SWIDTH),
    .BP   (H_BPORCH),
    .W    (COORD_W)
  ) u_hAxis (
    .clk_i    (VGA_CLK),
    .rst_n_i  (RST_N),
    .step_i   (run),
    .cnt_o    (hCnt),
    .last_o   (hLast),
    .active_o (hActive),
    .sync_o   (hSyncWin)
  );

  vga_axis_counter #(
    .ACT  (V_ACTIVE),
    .FP   (V_FPORCH),
    .SYNC (V_SWIDTH),
    .BP   (V_BPORCH),
    .W    (COORD_W)
  ) u_vAxis (
    .clk_i    (VGA_CLK),
    .rst_n_i  (RST_N),
    .step_i   (run && hLast),
    .cnt_o    (vCnt),
    .last_o   (vLast),
    .active_o (vActive),
    .sync_o   (vSyncWin)
  );

  // STOP only ever leaves for IDLE at a frame boundary, so frames are never cut short.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (EN) state_d = ST_RUN;
      ST_RUN:  if (!EN) state_d = ST_STOP;
      ST_STOP: begin
        if (frameEnd) begin
          state_d = ST_IDLE;
        end else if (EN) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    valid_d    = run && hActive && vActive;
    xPos_d     = valid_d ? hCnt : '0;
    yPos_d     = valid_d ? vCnt : '0;
    hsync_d    = (run && hSyncWin) ? SYNC_LEVEL : ~SYNC_LEVEL;
    vsync_d    = (run && vSyncWin) ? SYNC_LEVEL : ~SYNC_LEVEL;
    sof_d      = run && (hCnt == '0) && (vCnt == '0);
    busy_d     = run;
    frameCnt_d = frameEnd ? frameCnt_q + 1'b1 : frameCnt_q;
  end

  // Every output is a register fed from the current counters, giving one cycle of latency.
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      xPos_q     <= '0;
      yPos_q     <= '0;
      valid_q    <= 1'b0;
      hsync_q    <= ~SYNC_LEVEL;
      vsync_q    <= ~SYNC_LEVEL;
      sof_q      <= 1'b0;
      busy_q     <= 1'b0;
      frameCnt_q <= '0;
    end else begin
      xPos_q     <= xPos_d;
      yPos_q     <= yPos_d;
      valid_q    <= valid_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      sof_q      <= sof_d;
      busy_q     <= busy_d;
      frameCnt_q <= frameCnt_d;
    end
  end

  assign X         = xPos_q;
  assign Y         = yPos_q;
  assign valid     = valid_q;
  assign HSYNC     = hsync_q;
  assign VSYNC     = vsync_q;
  assign SOF       = sof_q;
  assign BUSY      = busy_q;
  assign FRAME_CNT = frameCnt_q;

endmodule

// File: tb/tb_vga_sync_module.sv
// Directed bench: a shrunk 10x7 raster (active-low and active-high sync copies)
// plus a full 640x480 instance for first-line timing.
module tb_vga_sync_module;

  logic clk;
  logic rstN;
  logic en;

  logic [10:0] xS, yS, xI, yI, xF, yF;
  logic        validS, hsS, vsS, sofS, busyS;
  logic        validI, hsI, vsI, sofI, busyI;
  logic        validF, hsF, vsF, sofF, busyF;
  logic [7:0]  fcS, fcI, fcF;

  int compared = 0;
  int mismatched = 0;
  int invBad = 0;

  logic        sofA[0:800], validA[0:800], hsA[0:800], vsA[0:800], busyA[0:800];
  logic [10:0] xA[0:800], yA[0:800];
  logic [7:0]  fcA[0:800];
  logic        validFA[0:800], hsFA[0:800];
  logic [10:0] xFA[0:800], yFA[0:800];

  // Small raster: H 4+2+3+1 = 10 (sync hc 6..8), V 3+1+2+1 = 7 (sync vc 4..5), 70 clocks/frame.
  vga_sync_module #(
    .H_ACTIVE(4), .H_FPORCH(2), .H_SWIDTH(3), .H_BPORCH(1),
    .V_ACTIVE(3), .V_FPORCH(1), .V_SWIDTH(2), .V_BPORCH(1),
    .COORD_W(11), .SYNC_LEVEL(1'b0)
  ) dutS (
    .VGA_CLK(clk), .RST_N(rstN), .EN(en), .X(xS), .Y(yS), .valid(validS),
    .HSYNC(hsS), .VSYNC(vsS), .SOF(sofS), .BUSY(busyS), .FRAME_CNT(fcS)
  );

  vga_sync_module #(
    .H_ACTIVE(4), .H_FPORCH(2), .H_SWIDTH(3), .H_BPORCH(1),
    .V_ACTIVE(3), .V_FPORCH(1), .V_SWIDTH(2), .V_BPORCH(1),
    .COORD_W(11), .SYNC_LEVEL(1'b1)
  ) dutI (
    .VGA_CLK(clk), .RST_N(rstN), .EN(en), .X(xI), .Y(yI), .valid(validI),
    .HSYNC(hsI), .VSYNC(vsI), .SOF(sofI), .BUSY(busyI), .FRAME_CNT(fcI)
  );

  vga_sync_module dutF (
    .VGA_CLK(clk), .RST_N(rstN), .EN(en), .X(xF), .Y(yF), .valid(validF),
    .HSYNC(hsF), .VSYNC(vsF), .SOF(sofF), .BUSY(busyF), .FRAME_CNT(fcF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic record(input int k);
    sofA[k] = sofS; validA[k] = validS; hsA[k] = hsS; vsA[k] = vsS;
    busyA[k] = busyS; xA[k] = xS; yA[k] = yS; fcA[k] = fcS;
    validFA[k] = validF; hsFA[k] = hsF; xFA[k] = xF; yFA[k] = yF;
    if (hsI === hsS || vsI === vsS) invBad++;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    en = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({xS, yS, validS, sofS, busyS, fcS, hsS, vsS} !== {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL reset_small: got %h expected %h",
               {xS, yS, validS, sofS, busyS, fcS, hsS, vsS}, {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1});
    end
    compared++;
    if ({hsI, vsI, validI, busyI} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_inv: got %b expected 0000", {hsI, vsI, validI, busyI});
    end
    compared++;
    if ({xF, yF, validF, sofF, busyF, fcF, hsF, vsF} !== {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL reset_full: got %h", {xF, yF, validF, sofF, busyF, fcF, hsF, vsF});
    end
    rstN = 1'b1;
    repeat (5) @(negedge clk);
    compared++;
    if ({busyS, sofS, validS} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL idle_en_low: busy/sof/valid got %b expected 000", {busyS, sofS, validS});
    end
  endtask

  task automatic test_first_frame();
    en = 1'b1;
    @(negedge clk);
    compared++;
    if ({sofS, busyS} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL start_latency1: sof/busy got %b expected 00", {sofS, busyS});
    end
    @(negedge clk);
    compared++;
    if ({sofS, busyS, validS, xS, yS} !== {1'b1, 1'b1, 1'b1, 11'd0, 11'd0}) begin
      mismatched++;
      $display("[TB] FAIL start_sof: got %h expected %h", {sofS, busyS, validS, xS, yS}, {1'b1, 1'b1, 1'b1, 11'd0, 11'd0});
    end
    compared++;
    if (sofF !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL start_sof_full: got %b expected 1", sofF);
    end
    invBad = 0;
    record(0);
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      record(k);
    end

    compared++;
    if ({validA[3], xA[3], yA[3]} !== {1'b1, 11'd3, 11'd0}) begin
      mismatched++;
      $display("[TB] FAIL pix_hc3_vc0: got %h", {validA[3], xA[3], yA[3]});
    end
    compared++;
    if ({validA[4], xA[4], yA[4]} !== {1'b0, 11'd0, 11'd0}) begin
      mismatched++;
      $display("[TB] FAIL pix_hc4_vc0: got %h expected 0", {validA[4], xA[4], yA[4]});
    end
    compared++;
    if ({validA[23], xA[23], yA[23]} !== {1'b1, 11'd3, 11'd2}) begin
      mismatched++;
      $display("[TB] FAIL pix_last_active: got %h", {validA[23], xA[23], yA[23]});
    end
    compared++;
    if ({validA[24], xA[24], validA[30], yA[30]} !== {1'b0, 11'd0, 1'b0, 11'd0}) begin
      mismatched++;
      $display("[TB] FAIL pix_after_active: got %h expected 0", {validA[24], xA[24], validA[30], yA[30]});
    end
    compared++;
    if ({hsA[5], hsA[6], hsA[8], hsA[9]} !== 4'b1001) begin
      mismatched++;
      $display("[TB] FAIL hsync_edges: got %b expected 1001", {hsA[5], hsA[6], hsA[8], hsA[9]});
    end
    compared++;
    if ({vsA[39], vsA[40], vsA[59], vsA[60]} !== 4'b1001) begin
      mismatched++;
      $display("[TB] FAIL vsync_edges: got %b expected 1001", {vsA[39], vsA[40], vsA[59], vsA[60]});
    end
    begin
      int nValid, nHs, nVs, nSof;
      nValid = 0; nHs = 0; nVs = 0; nSof = 0;
      for (int k = 0; k < 70; k++) begin
        if (validA[k] === 1'b1) nValid++;
        if (hsA[k] === 1'b0) nHs++;
        if (vsA[k] === 1'b0) nVs++;
      end
      for (int k = 0; k <= 800; k++) if (sofA[k] === 1'b1) nSof++;
      compared++;
      if (nValid != 12 || nHs != 21 || nVs != 20) begin
        mismatched++;
        $display("[TB] FAIL frame_counts: valid/hs/vs got %0d/%0d/%0d expected 12/21/20", nValid, nHs, nVs);
      end
      compared++;
      if (nSof != 12 || sofA[70] !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL sof_period: count got %0d expected 12, sof@70 got %b", nSof, sofA[70]);
      end
    end
    compared++;
    if ({fcA[68], fcA[69], fcA[800]} !== {8'd0, 8'd1, 8'd11}) begin
      mismatched++;
      $display("[TB] FAIL frame_cnt: got %0d/%0d/%0d expected 0/1/11", fcA[68], fcA[69], fcA[800]);
    end
    compared++;
    if (invBad != 0) begin
      mismatched++;
      $display("[TB] FAIL sync_pol_invert: got %0d non-inverted cycles expected 0", invBad);
    end

    // Full-size raster, first line only.
    begin
      int nLow, firstLow, lastLow, nValid;
      nLow = 0; firstLow = -1; lastLow = -1; nValid = 0;
      for (int k = 0; k < 800; k++) begin
        if (hsFA[k] === 1'b0) begin
          nLow++;
          if (firstLow < 0) firstLow = k;
          lastLow = k;
        end
        if (validFA[k] === 1'b1) nValid++;
      end
      compared++;
      if (nLow != 96 || firstLow != 656 || lastLow != 751) begin
        mismatched++;
        $display("[TB] FAIL full_hsync: low %0d..%0d (%0d) expected 656..751 (96)", firstLow, lastLow, nLow);
      end
      compared++;
      if (nValid != 640) begin
        mismatched++;
        $display("[TB] FAIL full_valid_line: got %0d expected 640", nValid);
      end
    end
    compared++;
    if ({validFA[639], xFA[639], validFA[640], xFA[640]} !== {1'b1, 11'd639, 1'b0, 11'd0}) begin
      mismatched++;
      $display("[TB] FAIL full_line_edge: X@639 got %0d, valid@640 got %b X@640 got %0d", xFA[639], validFA[640], xFA[640]);
    end
    compared++;
    if ({validFA[800], xFA[800], yFA[800]} !== {1'b1, 11'd0, 11'd1}) begin
      mismatched++;
      $display("[TB] FAIL full_line2: got valid %b X %0d Y %0d expected 1/0/1", validFA[800], xFA[800], yFA[800]);
    end
  endtask

  task automatic test_stop();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (sofS === 1'b1) found = 1'b1;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("[TB] FAIL stop_wait_sof: no SOF within 100 cycles");
    end
    compared++;
    if (fcS !== 8'd12) begin
      mismatched++;
      $display("[TB] FAIL stop_fc_start: got %0d expected 12", fcS);
    end
    record(0);
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      record(k);
      if (k == 15) en = 1'b0;
    end
    compared++;
    if ({validA[20], xA[20], yA[20], vsA[40]} !== {1'b1, 11'd0, 11'd2, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL stop_frame_continues: got %h", {validA[20], xA[20], yA[20], vsA[40]});
    end
    compared++;
    if ({busyA[69], busyA[70], fcA[69], fcA[99]} !== {1'b1, 1'b0, 8'd13, 8'd13}) begin
      mismatched++;
      $display("[TB] FAIL stop_end: busy %b%b fc %0d/%0d expected 10 13/13", busyA[69], busyA[70], fcA[69], fcA[99]);
    end
    begin
      int nSof, nAct;
      nSof = 0; nAct = 0;
      for (int k = 1; k < 100; k++) if (sofA[k] === 1'b1) nSof++;
      for (int k = 70; k < 100; k++) if (validA[k] !== 1'b0 || hsA[k] !== 1'b1 || vsA[k] !== 1'b1) nAct++;
      compared++;
      if (nSof != 0 || nAct != 0) begin
        mismatched++;
        $display("[TB] FAIL stop_idle_quiet: sof %0d active %0d expected 0/0", nSof, nAct);
      end
    end
  endtask

  task automatic test_resume();
    en = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (sofS !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL resume_start_sof: got %b expected 1", sofS);
    end
    record(0);
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      record(k);
      if (k == 10) en = 1'b0;
      if (k == 30) en = 1'b1;
    end
    compared++;
    if ({xA[11], yA[11], xA[21], yA[21], xA[22], yA[22]} !== {11'd1, 11'd1, 11'd1, 11'd2, 11'd2, 11'd2}) begin
      mismatched++;
      $display("[TB] FAIL resume_continuity: got %h", {xA[11], yA[11], xA[21], yA[21], xA[22], yA[22]});
    end
    begin
      int nSof, nIdle;
      nSof = 0; nIdle = 0;
      for (int k = 1; k < 70; k++) if (sofA[k] === 1'b1) nSof++;
      for (int k = 0; k <= 70; k++) if (busyA[k] !== 1'b1) nIdle++;
      compared++;
      if (nSof != 0 || sofA[70] !== 1'b1 || nIdle != 0) begin
        mismatched++;
        $display("[TB] FAIL resume_period: extra sof %0d, sof@70 %b, not-busy %0d", nSof, sofA[70], nIdle);
      end
    end
    compared++;
    if (fcA[69] !== 8'd14) begin
      mismatched++;
      $display("[TB] FAIL resume_fc: got %0d expected 14", fcA[69]);
    end
  endtask

  task automatic test_frame_end_drop();
    record(0);
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      record(k);
      if (k == 68) en = 1'b0;
    end
    compared++;
    if ({fcA[69], sofA[70], validA[73], xA[73]} !== {8'd15, 1'b1, 1'b1, 11'd3}) begin
      mismatched++;
      $display("[TB] FAIL fend_extra_frame: fc %0d sof %b valid %b X %0d", fcA[69], sofA[70], validA[73], xA[73]);
    end
    compared++;
    if ({busyA[139], busyA[140], fcA[139], fcA[150]} !== {1'b1, 1'b0, 8'd16, 8'd16}) begin
      mismatched++;
      $display("[TB] FAIL fend_stop: busy %b%b fc %0d/%0d expected 10 16/16", busyA[139], busyA[140], fcA[139], fcA[150]);
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    repeat (2) @(negedge clk);
    repeat (23) @(negedge clk);
    compared++;
    if ({validS, xS, yS} !== {1'b1, 11'd3, 11'd2}) begin
      mismatched++;
      $display("[TB] FAIL rmid_pre: got %h", {validS, xS, yS});
    end
    #1 rstN = 1'b0;
    #1;
    compared++;
    if ({xS, yS, validS, sofS, busyS, fcS, hsS, vsS} !== {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL rmid_async: got %h", {xS, yS, validS, sofS, busyS, fcS, hsS, vsS});
    end
    compared++;
    if ({hsI, vsI, fcF, busyF} !== {1'b0, 1'b0, 8'd0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL rmid_async_other: got %h", {hsI, vsI, fcF, busyF});
    end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    compared++;
    if ({sofS, busyS} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL rmid_restart1: sof/busy got %b expected 00", {sofS, busyS});
    end
    @(negedge clk);
    compared++;
    if ({sofS, busyS, validS, fcS} !== {1'b1, 1'b1, 1'b1, 8'd0}) begin
      mismatched++;
      $display("[TB] FAIL rmid_restart_sof: got %h", {sofS, busyS, validS, fcS});
    end
  endtask

  task automatic test_wrap();
    int nSof;
    logic [7:0] fc17848, fc17849, fc17919, fc17989;
    nSof = 1;
    invBad = 0;
    fc17848 = 8'hxx; fc17849 = 8'hxx; fc17919 = 8'hxx; fc17989 = 8'hxx;
    for (int k = 1; k <= 17989; k++) begin
      @(negedge clk);
      if (sofS === 1'b1) nSof++;
      if (hsI === hsS || vsI === vsS) invBad++;
      if (k == 17848) fc17848 = fcS;
      if (k == 17849) fc17849 = fcS;
      if (k == 17919) fc17919 = fcS;
      if (k == 17989) fc17989 = fcS;
    end
    compared++;
    if ({fc17848, fc17849, fc17919, fc17989} !== {8'd254, 8'd255, 8'd0, 8'd1}) begin
      mismatched++;
      $display("[TB] FAIL fc_wrap: got %0d/%0d/%0d/%0d expected 254/255/0/1", fc17848, fc17849, fc17919, fc17989);
    end
    compared++;
    if (nSof != 257) begin
      mismatched++;
      $display("[TB] FAIL wrap_sof_count: got %0d expected 257", nSof);
    end
    compared++;
    if (invBad != 0) begin
      mismatched++;
      $display("[TB] FAIL wrap_sync_pol: got %0d non-inverted cycles expected 0", invBad);
    end
  endtask

  initial begin
    rstN = 1'b0;
    en = 1'b0;
    test_reset();
    test_first_frame();
    test_stop();
    test_resume();
    test_frame_end_drop();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_sync_module.md
VGA_SYNC_MODULE -- requirements
Module: vga_sync_module

Interface
REQ-001 Parameters SHALL come from `vga_params.v`, one per line: `H_ACT` 640 active pixels; `H_FP` 16 h front porch; `H_SYNC` 96 h sync width; `H_BP` 48 h back porch; `V_ACT` 480 active lines; `V_FP` 10; `V_SYNC` 2; `V_BP` 33; `P_WIDTH` 11 coordinate width; `SYNC_POL` 0 sync pulse level (0 = active-low).
REQ-002 Ports SHALL be, one per line:
- `VGA_CLK` in 1 pixel clock; the only clock.
- `RST_N` in 1 reset; asynchronous, active-low.
- `EN` in 1 run request.
- `X` out `P_WIDTH` pixel column.
- `Y` out `P_WIDTH` pixel row.
- `valid` out 1 pixel inside active area.
- `HSYNC` out 1 horizontal sync.
- `VSYNC` out 1 vertical sync.
- `SOF` out 1 one-cycle start-of-frame pulse.
- `BUSY` out 1 timing running.
- `FRAME_CNT` out 8 completed-frame count.

Function
REQ-003 `H_TOT` = `H_ACT`+`H_FP`+`H_SYNC`+`H_BP` (800) and `V_TOT` (525) SHALL be derived constants; `P_WIDTH` SHALL hold `H_TOT`-1 and `V_TOT`-1.
REQ-004 Internal `hc` SHALL count 0..`H_TOT`-1 and wrap to 0. `vc` SHALL increment only on the `hc` wrap and itself wrap from `V_TOT`-1 to 0.
REQ-005 The FSM SHALL have three states:
- IDLE: counters held at 0; `BUSY`=0.
- RUN: counters advance; `BUSY`=1.
- STOP: counters advance until the frame ends; `BUSY`=1.
REQ-006 IDLE->RUN SHALL occur on the first clock with `EN`=1. The cycle after the transition SHALL present `hc`=0, `vc`=0.
REQ-007 RUN->STOP SHALL occur when `EN`=0. STOP->RUN SHALL occur if `EN` returns to 1 before the frame ends; the frame continues with no restart.
REQ-008 STOP->IDLE SHALL occur on the cycle with `hc`=`H_TOT`-1 and `vc`=`V_TOT`-1. A frame is never truncated.
REQ-009 All outputs SHALL be registered and reflect `hc`/`vc` with exactly one cycle of latency.
REQ-010 `valid` SHALL be 1 iff not IDLE, `hc`<`H_ACT` and `vc`<`V_ACT`.
REQ-011 `X`/`Y` SHALL equal `hc`/`vc` when `valid`=1, else 0.
REQ-012 `HSYNC` SHALL be at `SYNC_POL` level iff `H_ACT`+`H_FP` <= `hc` < `H_ACT`+`H_FP`+`H_SYNC`, else the inverse.
REQ-013 `VSYNC` SHALL follow the same rule on `vc` with the vertical parameters.
REQ-014 In IDLE, both `HSYNC` and `VSYNC` SHALL sit at the inactive level.
REQ-015 `SOF` SHALL pulse for exactly one cycle, aligned with the output of `hc`=0, `vc`=0, in RUN or STOP.
REQ-016 `FRAME_CNT` SHALL increment modulo 256 at each frame end (`hc`=`H_TOT`-1, `vc`=`V_TOT`-1). It SHALL hold in IDLE and SHALL NOT be cleared by `EN`.
REQ-017 When a frame end and `EN` falling occur in the same cycle in RUN, the FSM SHALL enter STOP and run one further full frame.

Reset
REQ-018 `RST_N`=0 SHALL asynchronously force:
- FSM to IDLE.
- `hc`=`vc`=0.
- `X`=`Y`=0, `valid`=0, `SOF`=0, `BUSY`=0, `FRAME_CNT`=0.
- `HSYNC`=`VSYNC`= inactive level.
REQ-019 Reset asserted mid-frame SHALL abandon the frame immediately.
REQ-020 After `RST_N` deasserts, the block SHALL behave per REQ-006: a new frame starts only on `EN`=1.

Structure
REQ-021 Timing parameters, `P_WIDTH`, `D_WIDTH`, `H_TOT`, `V_TOT` and the FSM state encodings SHALL live in the shared `vga_params.v`. This block SHALL define no local timing constants.
REQ-022 The design SHALL be one module with no sub-module. A reusable `vga_axis_counter` (wrap counter plus sync window, instantiated for H and V) is permitted.

Verification
REQ-023 Reset then `EN`=1 held:
- first `SOF` 2 cycles after `EN` is sampled;
- `HSYNC` low for `hc` 656..751;
- `VSYNC` low for lines 490..491;
- 800 clocks per line, 420000 clocks per frame.
REQ-024 Active-area check: `valid` high for exactly 640 x 480 = 307200 cycles per frame. At `hc`=639 with `vc`=479, `X`=639 and `Y`=479. One cycle later, `valid`=0 and `X`=0.
REQ-025 `EN` dropped at line 100 of frame 3:
- blanking continues to line 524;
- `BUSY` falls after frame end;
- `FRAME_CNT`=3;
- no further `SOF`.
REQ-026 `EN` dropped then re-raised within the same frame: no discontinuity in `hc`/`vc`, and the `SOF` period stays 420000.
REQ-027 `RST_N` pulsed low mid-line (`hc`=300, `vc`=200): all outputs reach reset values without a clock edge. After release with `EN`=1, the next `SOF` follows REQ-006.
REQ-028 Run 257 frames: `FRAME_CNT` wraps 255->0->1. With `SYNC_POL`=1, both sync outputs are inverted relative to the `SYNC_POL`=0 run.
